fpu_normalizer_core: RTL and testbench

Post-arithmetic normalization stage of the floating-point unit. Takes a 24-bit unnormalized significand (hidden-bit position at bit 23) and an 8-bit biased exponent. Left-shifts the significand until its leading one reaches bit 23 and decrements the exponent by the shift amount. Emits the 23-bit stored fraction, the adjusted exponent and overflow/underflow flags, registered, one cycle after the input is accepted.

---
 rtl/fpu_normalizer_core.sv | 131 +++++++++++++
 tb/tb_fpu_normalizer_core.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fpu_normalizer_core.sv
// -----------------------------------------------------------------------------
// fpu_normalizer_core
//
// Post-arithmetic normalization stage for IEEE-754 single precision.
// A 24-bit unnormalized significand (hidden-bit position at bit 23) is
// left-shifted until its leading one sits at bit 23. The biased exponent is
// reduced by the same shift amount. The stage produces the 23-bit stored
// fraction, the adjusted exponent and the overflow/underflow flags. All
// outputs are registered, one cycle after the input is accepted.
//
// Ports
//   clk                  in   1   sole clock, rising-edge active
//   rst_n                in   1   synchronous active-low reset
//   in_valid             in   1   mantissa/exponent valid this cycle
//   mantissa             in  24   unnormalized significand
//   exponent             in   8   biased exponent of mantissa
//   out_valid            out  1   outputs carry a new result this cycle
//   normalized_mantissa  out 23   stored fraction (hidden bit dropped)
//   normalized_exponent  out  8   adjusted biased exponent
//   overflow             out  1   exponent saturated to 8'hFF (infinity)
//   underflow            out  1   result flushed to zero
// -----------------------------------------------------------------------------
module fpu_normalizer_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [23:0] mantissa,
  input  logic [7:0]  exponent,
  output logic        out_valid,
  output logic [22:0] normalized_mantissa,
  output logic [7:0]  normalized_exponent,
  output logic        overflow,
  output logic        underflow
);

  // Exponent value that encodes infinity, in the 9-bit working width.
  localparam logic [8:0] EXP_INF_WIDE = 9'h0FF;

  // Shift amount = number of zeros above the leading one. The loop runs
  // from the LSB upward so the highest set bit is the last one written and
  // wins. An all-zero input returns 0; the zero case is handled separately.
  function automatic logic [4:0] leading_zero_count(input logic [23:0] m);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (m[i]) begin
        cnt = 5'(23 - i);
      end else begin
        cnt = cnt;
      end
    end
    return cnt;
  endfunction

  logic [4:0]  shift_s;
  logic [8:0]  exp_wide_s;
  logic        is_zero_s;
  logic        is_underflow_s;
  logic        is_overflow_s;
  logic [22:0] next_frac_s;
  logic [7:0]  next_exp_s;
  logic        next_ovf_s;
  logic        next_udf_s;

  logic        out_valid_r;
  logic [22:0] frac_r;
  logic [7:0]  exp_r;
  logic        ovf_r;
  logic        udf_r;

  // Leading-one detection and the 9-bit exponent difference. Working in
  // 9 bits means exponent < shift cannot wrap into a large positive value.
  always_comb begin
    shift_s        = leading_zero_count(mantissa);
    exp_wide_s     = {1'b0, exponent} - {4'b0000, shift_s};
    is_zero_s      = (mantissa == 24'd0);
    is_underflow_s = ({1'b0, exponent} <= {4'b0000, shift_s});
    is_overflow_s  = (exp_wide_s == EXP_INF_WIDE);
  end

  // Result selection in priority order: zero, underflow, overflow, normal.
  always_comb begin
    next_frac_s = 23'd0;
    next_exp_s  = 8'd0;
    next_ovf_s  = 1'b0;
    next_udf_s  = 1'b0;
    if (is_zero_s) begin
      next_frac_s = 23'd0;
      next_exp_s  = 8'd0;
    end else if (is_underflow_s) begin
      // No denormal output: anything that would reach exponent <= 0 is
      // flushed to zero.
      next_udf_s  = 1'b1;
    end else if (is_overflow_s) begin
      // This can only happen with exponent 8'hFF and no shift.
      next_exp_s  = 8'hFF;
      next_ovf_s  = 1'b1;
    end else begin
      // The shifted hidden bit lands on bit 23 and is dropped by truncation.
      next_frac_s = 23'(mantissa << shift_s);
      next_exp_s  = exp_wide_s[7:0];
    end
  end

  // Output register. Reset overrides in_valid. Without in_valid, only
  // out_valid drops and the data/flags hold their previous values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      frac_r      <= 23'd0;
      exp_r       <= 8'd0;
      ovf_r       <= 1'b0;
      udf_r       <= 1'b0;
    end else if (in_valid) begin
      out_valid_r <= 1'b1;
      frac_r      <= next_frac_s;
      exp_r       <= next_exp_s;
      ovf_r       <= next_ovf_s;
      udf_r       <= next_udf_s;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid           = out_valid_r;
  assign normalized_mantissa = frac_r;
  assign normalized_exponent = exp_r;
  assign overflow            = ovf_r;
  assign underflow           = udf_r;

endmodule

// File: tb/tb_fpu_normalizer_core.sv
// -----------------------------------------------------------------------------
// tb_fpu_normalizer_core
//
// Self-checking bench for fpu_normalizer_core. Directed steps from the test
// plan are followed by randomized traffic. Each cycle's expected output comes
// from an arithmetic reference model of the normalization rules.
// -----------------------------------------------------------------------------
module tb_fpu_normalizer_core;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] mantissa;
  logic [7:0]  exponent;
  logic        out_valid;
  logic [22:0] normalized_mantissa;
  logic [7:0]  normalized_exponent;
  logic        overflow;
  logic        underflow;

  int tests_run;
  int tests_failed;

  // Expected register contents; these are held across idle cycles.
  logic [22:0] exp_frac;
  logic [7:0]  exp_expo;
  logic        exp_ovf;
  logic        exp_udf;

  fpu_normalizer_core dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_valid            (in_valid),
    .mantissa            (mantissa),
    .exponent            (exponent),
    .out_valid           (out_valid),
    .normalized_mantissa (normalized_mantissa),
    .normalized_exponent (normalized_exponent),
    .overflow            (overflow),
    .underflow           (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. The position of the leading one is floor(log2 m), so
  // s = 23 - floor(log2 m) = 24 - clog2(m+1). Normal fraction = (m * 2^s) mod 2^23.
  task automatic model(input logic [23:0] m, input logic [7:0] e,
                       output logic [22:0] f, output logic [7:0] x,
                       output logic o, output logic u);
    longint mi;
    longint s;
    longint ev;
    longint prod;
    mi = longint'(m);
    ev = longint'(e);
    f = 23'd0; x = 8'd0; o = 1'b0; u = 1'b0;
    if (mi == 0) begin
      f = 23'd0;
    end else begin
      s = 64'd24 - longint'($clog2(mi + 1));
      if (ev <= s) begin
        u = 1'b1;
      end else if (ev - s == 255) begin
        x = 8'hFF;
        o = 1'b1;
      end else begin
        prod = (mi * (longint'(1) << s)) % 64'd8388608;
        f = prod[22:0];
        x = 8'(ev - s);
      end
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_vec(input string tag, input logic [22:0] obs, input logic [22:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, then check the registered result after the edge.
  task automatic step(input logic r, input logic v, input logic [23:0] m, input logic [7:0] e);
    logic [22:0] f;
    logic [7:0]  x;
    logic        o;
    logic        u;
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    mantissa = m;
    exponent = e;
    @(posedge clk);
    #1;
    if (!r) begin
      exp_frac = 23'd0; exp_expo = 8'd0; exp_ovf = 1'b0; exp_udf = 1'b0;
      check_bit("rst_valid", out_valid, 1'b0);
    end else if (v) begin
      model(m, e, f, x, o, u);
      exp_frac = f; exp_expo = x; exp_ovf = o; exp_udf = u;
      check_bit("valid", out_valid, 1'b1);
    end else begin
      check_bit("idle_valid", out_valid, 1'b0);
    end
    check_vec("frac", normalized_mantissa, exp_frac);
    check_vec("exp", {15'd0, normalized_exponent}, {15'd0, exp_expo});
    check_bit("ovf", overflow, exp_ovf);
    check_bit("udf", underflow, exp_udf);
  endtask

  // Directed anchors with hand-computed values, independent of the model.
  task automatic check_literal(input string tag, input logic [22:0] f,
                               input logic [7:0] x, input logic o, input logic u);
    check_vec({tag, "_frac"}, normalized_mantissa, f);
    check_vec({tag, "_exp"}, {15'd0, normalized_exponent}, {15'd0, x});
    check_bit({tag, "_ovf"}, overflow, o);
    check_bit({tag, "_udf"}, underflow, u);
  endtask

  initial begin
    logic [23:0] rm;
    logic [7:0]  re;
    tests_run = 0;
    tests_failed = 0;
    exp_frac = 23'd0; exp_expo = 8'd0; exp_ovf = 1'b0; exp_udf = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; mantissa = 24'd0; exponent = 8'd0;

    // Reset held for two cycles with a valid input present.
    step(1'b0, 1'b1, 24'h800000, 8'd5);
    step(1'b0, 1'b1, 24'h800000, 8'd5);
    check_literal("reset", 23'd0, 8'd0, 1'b0, 1'b0);

    // First accepted input after release appears one cycle later.
    step(1'b1, 1'b1, 24'h800000, 8'd5);
    check_literal("norm0", 23'd0, 8'd5, 1'b0, 1'b0);

    // Underflow sweep, back-to-back.
    step(1'b1, 1'b1, 24'h000001, 8'd0);
    check_literal("udf0", 23'd0, 8'd0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 24'h000001, 8'd1);
    check_literal("udf1", 23'd0, 8'd0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 24'h000002, 8'd2);
    check_literal("udf2", 23'd0, 8'd0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 24'h100000, 8'd3);
    check_literal("udf3", 23'd0, 8'd0, 1'b0, 1'b1);

    // Normal shift, fraction retention, extremes.
    step(1'b1, 1'b1, 24'h400000, 8'd4);
    check_literal("shift1", 23'd0, 8'd3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 24'h00C000, 8'd100);
    check_literal("retain", 23'h400000, 8'd92, 1'b0, 1'b0);
    step(1'b1, 1'b1, 24'hFFFFFF, 8'hFF);
    check_literal("ovf", 23'd0, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 1'b1, 24'h000000, 8'd77);
    check_literal("zero", 23'd0, 8'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 24'hABCDEF, 8'd200);
    check_literal("full", 23'h2BCDEF, 8'd200, 1'b0, 1'b0);

    // Idle cycle: data holds, out_valid drops.
    step(1'b1, 1'b0, 24'h000001, 8'd9);
    check_literal("hold", 23'h2BCDEF, 8'd200, 1'b0, 1'b0);

    // Mid-stream reset drops the input presented with it.
    step(1'b1, 1'b1, 24'h000300, 8'd50);
    step(1'b0, 1'b1, 24'h123456, 8'd60);
    check_literal("midrst", 23'd0, 8'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 24'h123456, 8'd60);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      rm = 24'($urandom()) >> $urandom_range(0, 24);
      case ($urandom_range(0, 3))
        0:       re = 8'($urandom_range(0, 24));
        1:       re = 8'hFF;
        default: re = 8'($urandom());
      endcase
      step(1'b1, ($urandom_range(0, 3) != 0), rm, re);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
